// File: rtl/parity_check_scheduler.sv
// Shares one odd-parity check stage between NUM_REQ requesters. Arbitration is round-robin,
// results go out on a valid/ready channel, and each requester has a saturating error counter.
module parity_check_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4,
    parameter int CNT_W   = 8,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_p,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        res_valid,
    output logic [ID_W-1:0]             res_id,
    output logic                        res_error,
    input  logic                        res_ready,
    input  logic                        clr_counts,
    output logic [NUM_REQ*CNT_W-1:0]    err_count
);

    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                p_q, p_d;
    logic                res_valid_q, res_valid_d;
    logic                res_error_q, res_error_d;
    logic [CNT_W-1:0]    cnt_q [NUM_REQ];
    logic [CNT_W-1:0]    cnt_d [NUM_REQ];

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_id;
    logic                grant_found;
    logic [ID_W:0]       cand_sum;
    logic [ID_W-1:0]     cand;
    logic                chk_err;

    // Rotating priority search starting at rr_ptr; reset also masks the grant.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        cand_sum    = '0;
        cand        = '0;
        if (state_q == IDLE && !rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
                if (cand_sum >= (ID_W+1)'(NUM_REQ)) begin
                    cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
                end
                cand = cand_sum[ID_W-1:0];
                if (!grant_found && req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant[cand] = 1'b1;
                    grant_id    = cand;
                end
            end
        end
    end

    assign chk_err = ~^{data_q, p_q};

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        data_d      = data_q;
        p_d         = p_q;
        res_valid_d = res_valid_q;
        res_error_d = res_error_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    data_d  = req_data[grant_id*DATA_W +: DATA_W];
                    p_d     = req_p[grant_id];
                    id_d    = grant_id;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                res_error_d = chk_err;
                res_valid_d = 1'b1;
                state_d     = RESP;
                if (chk_err && cnt_q[id_q] != {CNT_W{1'b1}}) begin
                    cnt_d[id_q] = cnt_q[id_q] + 1'b1;
                end
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    rr_ptr_d    = (id_q == ID_W'(NUM_REQ-1)) ? '0 : id_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A clear takes precedence over an increment landing on the same edge.
        if (clr_counts) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            data_q      <= '0;
            p_q         <= 1'b0;
            res_valid_q <= 1'b0;
            res_error_q <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            data_q      <= data_d;
            p_q         <= p_d;
            res_valid_q <= res_valid_d;
            res_error_q <= res_error_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready = grant;
    assign res_valid = res_valid_q;
    assign res_id    = id_q;
    assign res_error = res_error_q;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt_out
            assign err_count[gi*CNT_W +: CNT_W] = cnt_q[gi];
        end
    endgenerate

endmodule
